// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg : opcode encodings and default datapath width for alu_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_REM = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_BEQ = 4'b1001;
  localparam logic [3:0] ALU_BLT = 4'b1010;

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
//------------------------------------------------------------------------------
// alu_if : request/response bundle between the execute stage and alu_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       Alu_Control;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             hero;

  modport master (
    output in_valid, srcA, srcB, Alu_Control,
    input  out_valid, result, zero, hero
  );

  modport slave (
    input  in_valid, srcA, srcB, Alu_Control,
    output out_valid, result, zero, hero
  );

endinterface

`default_nettype wire

// File: rtl/alu_core.sv
//------------------------------------------------------------------------------
// alu_core : combinational result/zero/hero for one ALU operation.
// Optional macro ALU_DIV_EN adds the signed divide/remainder datapath.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             hero
);

  localparam int SHW = $clog2(WIDTH);

  logic           w_lt;
  logic [SHW-1:0] w_shamt;

  assign w_lt    = $signed(src_a) < $signed(src_b);
  assign w_shamt = src_b[SHW-1:0];

`ifdef ALU_DIV_EN
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Divide-by-zero and MIN/-1 overflow get fixed, well-defined results
  always_comb begin
    w_quot = '1;
    w_rem  = src_a;
    if (src_b == '0) begin
      w_quot = '1;
      w_rem  = src_a;
    end else if ((src_a == C_MIN) && (src_b == '1)) begin
      w_quot = C_MIN;
      w_rem  = '0;
    end else begin
      w_quot = $unsigned($signed(src_a) / $signed(src_b));
      w_rem  = $unsigned($signed(src_a) % $signed(src_b));
    end
  end
`endif

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_DIV_EN
      ALU_DIV: result = w_quot;
      ALU_REM: result = w_rem;
`endif
      ALU_SLL: result = src_a << w_shamt;
      ALU_SRL: result = src_a >> w_shamt;
      ALU_SRA: result = $unsigned($signed(src_a) >>> w_shamt);
      ALU_BEQ: result = src_a - src_b;
      ALU_BLT: result = src_a - src_b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign hero = (op == ALU_BLT) && w_lt;

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
//------------------------------------------------------------------------------
// alu_unit : registered 32-bit execute-stage ALU, 1-cycle latency, full rate.
// Optional macro ALU_DIV_EN enables DIV/REM opcodes.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_hero;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_hero;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .src_a  (bus.srcA),
    .src_b  (bus.srcB),
    .op     (bus.Alu_Control),
    .result (w_result),
    .zero   (w_zero),
    .hero   (w_hero)
  );

  // Data registers only load on valid input so they hold across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_hero   <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_result;
        r_zero   <= w_zero;
        r_hero   <= w_hero;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.hero      = r_hero;

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
//------------------------------------------------------------------------------
// tb_alu_unit : directed-vector scoreboard bench for alu_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_unit;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        zero;
    logic        hero;
  } exp_t;

`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  alu_if bus ();

  alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop one expectation per presented result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: result=%h with empty scoreboard", bus.result);
      end else begin
        e = sb.pop_front();
        if (bus.result !== e.result || bus.zero !== e.zero || bus.hero !== e.hero) begin
          n_fail++;
          $display("FAIL %s: got result=%h zero=%b hero=%b, expected result=%h zero=%b hero=%b",
                   e.name, bus.result, bus.zero, bus.hero, e.result, e.zero, e.hero);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input logic eh);
    exp_t e;
    e.name = name; e.result = er; e.zero = ez; e.hero = eh;
    bus.in_valid = 1'b1; bus.Alu_Control = op; bus.srcA = a; bus.srcB = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, "_result"},    bus.result,             32'd0);
    check({name, "_zero"},      {31'd0, bus.zero},      32'd0);
    check({name, "_hero"},      {31'd0, bus.hero},      32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.Alu_Control = 4'd0; bus.srcA = '0; bus.srcB = '0;
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue("add",        ALU_ADD, 32'd10,        32'd20,        32'd30,        1'b0, 1'b0);
    issue("add_wrap",   ALU_ADD, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0);
    issue("sub",        ALU_SUB, 32'd30,        32'd15,        32'd15,        1'b0, 1'b0);
    issue("and",        ALU_AND, 32'h1F,        32'h0A,        32'h0A,        1'b0, 1'b0);
    issue("slt_true",   ALU_SLT, 32'hFFFFFFF6,  32'd5,         32'd1,         1'b0, 1'b0);
    issue("slt_false",  ALU_SLT, 32'd5,         32'hFFFFFFF6,  32'd0,         1'b1, 1'b0);
    issue("div",        ALU_DIV, 32'd50,        32'd10,        DIV_ON ? 32'd5 : 32'd0,          !DIV_ON, 1'b0);
    issue("rem",        ALU_REM, 32'd31,        32'd4,         DIV_ON ? 32'd3 : 32'd0,          !DIV_ON, 1'b0);
    issue("div_by0",    ALU_DIV, 32'd7,         32'd0,         DIV_ON ? 32'hFFFFFFFF : 32'd0,   !DIV_ON, 1'b0);
    issue("rem_by0",    ALU_REM, 32'd7,         32'd0,         DIV_ON ? 32'd7 : 32'd0,          !DIV_ON, 1'b0);
    issue("div_ovf",    ALU_DIV, 32'h80000000,  32'hFFFFFFFF,  DIV_ON ? 32'h80000000 : 32'd0,   !DIV_ON, 1'b0);
    issue("rem_ovf",    ALU_REM, 32'h80000000,  32'hFFFFFFFF,  32'd0,                           1'b1,    1'b0);
    issue("div_neg",    ALU_DIV, 32'hFFFFFFF9,  32'd2,         DIV_ON ? 32'hFFFFFFFD : 32'd0,   !DIV_ON, 1'b0);
    issue("rem_neg",    ALU_REM, 32'hFFFFFFF9,  32'd2,         DIV_ON ? 32'hFFFFFFFF : 32'd0,   !DIV_ON, 1'b0);
    issue("sll",        ALU_SLL, 32'd8,         32'd2,         32'd32,        1'b0, 1'b0);
    issue("sll_by0",    ALU_SLL, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0);
    issue("srl",        ALU_SRL, 32'd16,        32'd2,         32'd4,         1'b0, 1'b0);
    issue("srl_lowbits",ALU_SRL, 32'h80000000,  32'h21,        32'h40000000,  1'b0, 1'b0);
    issue("sra",        ALU_SRA, 32'hFFFFFFF0,  32'd2,         32'hFFFFFFFC,  1'b0, 1'b0);
    issue("beq_equal",  ALU_BEQ, 32'd20,        32'd20,        32'd0,         1'b1, 1'b0);
    issue("beq_lt",     ALU_BEQ, 32'hFFFFFFFB,  32'd10,        32'hFFFFFFF1,  1'b0, 1'b0);
    issue("blt_taken",  ALU_BLT, 32'hFFFFFFFB,  32'd10,        32'hFFFFFFF1,  1'b0, 1'b1);
    issue("blt_not",    ALU_BLT, 32'd10,        32'hFFFFFFFB,  32'd15,        1'b0, 1'b0);
    issue("unused_b",   4'b1011, 32'd5,         32'd3,         32'd0,         1'b1, 1'b0);
    issue("unused_f",   4'b1111, 32'd5,         32'd3,         32'd0,         1'b1, 1'b0);
    issue("and_last",   ALU_AND, 32'h0000F0F0,  32'h0000FF00,  32'h0000F000,  1'b0, 1'b0);

    // Idle cycle: valid drops, data holds
    bus.in_valid = 1'b0;
    bus.Alu_Control = ALU_ADD; bus.srcA = 32'd1; bus.srcB = 32'd1;
    @(posedge clk);
    #1;
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("idle_hold_result", bus.result, 32'h0000F000);
    check("idle_hold_zero", {31'd0, bus.zero}, 32'd0);

    // Asynchronous reset while a result is being presented
    bus.in_valid = 1'b1; bus.Alu_Control = ALU_BLT; bus.srcA = 32'hFFFFFFFB; bus.srcB = 32'd10;
    @(posedge clk);
    #1;
    check("pre_reset_hero", {31'd0, bus.hero}, 32'd1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue("add_after_reset", ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered 32-bit integer ALU for the CPU execute stage; one operation per cycle selected by a 4-bit control code.
- Supports add, sub, and, signed set-less-than, signed divide/remainder, logical/arithmetic shifts, and branch compare (equal / signed less-than) with flags.
- Inputs are sampled when in_valid is high; result and flags are registered with a fixed 1-cycle latency.

Parameters:
- WIDTH, 32, operand/result width. Shift amount uses the low $clog2(WIDTH) bits of srcB.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/control valid this cycle.
- srcA  input  WIDTH  operand A, two's complement.
- srcB  input  WIDTH  operand B, two's complement; shift amount for shift ops.
- Alu_Control  input  4  operation select.
- out_valid  output  1  result/flags valid (registered).
- result  output  WIDTH  operation result (registered).
- zero  output  1  result equals 0 (registered).
- hero  output  1  branch-less-than taken flag (registered).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: out_valid=0, result=0, zero=0, hero=0, held until rst_n deasserts; reset mid-operation discards the in-flight op.
- Timing: on a clk rising edge with in_valid=1, capture the op outcome. out_valid=1 the next cycle.
- With in_valid=0: out_valid goes 0; result, zero and hero hold their last values.
- Back-to-back ops: full throughput, one per cycle, no stall.
- Opcodes (Alu_Control):
  - 0000 ADD: A+B, wraps mod 2^WIDTH.
  - 0001 SUB: A-B, wraps.
  - 0010 AND: A&B.
  - 0011 SLT: 1 if signed A<B, else 0.
  - 0100 DIV: signed quotient, truncated toward zero.
  - 0101 REM: signed remainder; sign follows A.
  - 0110 SLL: A << B[4:0].
  - 0111 SRL: A >> B[4:0], zero fill.
  - 1000 SRA: A >>> B[4:0], sign fill.
  - 1001 BEQ: result = A-B.
  - 1010 BLT: result = A-B.
  - 1011-1111: result = 0.
- Division boundaries:
  - B=0: DIV gives all ones (-1); REM gives A.
  - A=-2^(WIDTH-1) with B=-1: DIV gives A; REM gives 0.
- zero flag: registered (next result == 0) for every opcode, so BEQ with A==B gives zero=1.
- hero flag: 1 only for opcode 1010 with signed A<B; 0 for all other opcodes.
- Shifts by 0 return A unchanged.
- Result width is exactly WIDTH; no carry or overflow outputs.
- Division is combinational, single cycle.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: DIV/REM behave as above.
- Undefined: no divider logic is synthesised; opcodes 0100/0101 behave like unused codes (result 0, zero=1, hero=0).

Decomposition:
- Package alu_pkg: 4-bit opcode localparams (ALU_ADD..ALU_BLT) and the default WIDTH constant.
- Sub-module alu_core: purely combinational result/zero/hero computation.
- alu_unit wraps alu_core with the valid pipeline and output registers.

Test Plan:
- ADD: A=10, B=20, op 0000 -> next cycle result=30, zero=0, out_valid=1.
- SUB/AND: 30-15 -> 15; 0x1F & 0x0A -> 0x0A.
- SLT signed: A=-10, B=5, op 0011 -> result=1.
- DIV/REM: 50/10 -> 5; 31%4 -> 3.
- DIV/REM edge cases: 7/0 -> 0xFFFFFFFF; 7%0 -> 7; 0x80000000/-1 -> 0x80000000.
- Shifts: 8<<2 -> 32; 16>>2 -> 4; -16>>>2 -> -4 (0xFFFFFFFC).
- Branch ops and reset:
  - BEQ A=B=20 -> zero=1, hero=0.
  - BLT A=-5, B=10 -> hero=1.
  - BLT A=10, B=-5 -> hero=0.
  - Assert rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
